// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq -- multi-cycle ALU datapath driven by the ALU-control funct code.
//
// ADD, SUB and OR (and unrecognised codes) finish in a single execute cycle.
// SRL shifts one bit position per cycle, so it takes as many extra cycles as
// the shift amount. A start/busy/done handshake lets the CPU controller stall
// until the result is valid.
//
// Parameters:
//   WIDTH    operand/result width in bits
//   SHAMT_W  shift-amount width (2**SHAMT_W >= WIDTH)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (overrides everything)
//   start     in   request, sampled only while idle
//   funct     in   6-bit operation code
//   src1      in   operand A / SRL shift source
//   src2      in   operand B
//   shamt     in   SRL shift amount
//   busy      out  high from the cycle after acceptance until done
//   done      out  one-cycle pulse; result and flags valid, then held
//   result    out  registered result
//   zero      out  registered (result == 0)
//   overflow  out  registered signed overflow (ADD/SUB only)
//   illegal   out  registered: accepted funct was unrecognised
// ----------------------------------------------------------------------------
module alu_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [5:0] {
        OP_ADD = 6'b001001,
        OP_SUB = 6'b001010,
        OP_OR  = 6'b010010,
        OP_SRL = 6'b100010
    } op_t;

    state_t             state_q;

    // Operands captured on acceptance; live inputs are ignored while busy.
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [5:0]         funct_q;
    logic [SHAMT_W-1:0] shamt_q;

    // Serial shifter state.
    logic [WIDTH-1:0]   shreg_q;
    logic [SHAMT_W-1:0] cnt_q;

    // Registered outputs.
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               ill_q;
    logic               busy_q;
    logic               done_q;

    // Single-cycle execute results, computed from the captured operands.
    logic [WIDTH-1:0]   sum_d;
    logic [WIDTH-1:0]   diff_d;
    logic [WIDTH-1:0]   exec_res_d;
    logic               exec_ovf_d;
    logic               exec_ill_d;
    logic               exec_is_shift_d;
    logic [WIDTH-1:0]   shift_next_d;

    always_comb begin
        sum_d           = a_q + b_q;
        diff_d          = a_q - b_q;
        exec_res_d      = '0;
        exec_ovf_d      = 1'b0;
        exec_ill_d      = 1'b0;
        exec_is_shift_d = 1'b0;
        shift_next_d    = shreg_q >> 1;

        case (funct_q)
            OP_ADD: begin
                exec_res_d = sum_d;
                // Same-sign operands producing an opposite-sign sum.
                exec_ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res_d = diff_d;
                // Opposite-sign operands where the sign of A is not preserved.
                exec_ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (diff_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_OR: begin
                exec_res_d = a_q | b_q;
            end
            OP_SRL: begin
                // A zero shift completes here with the unshifted source;
                // otherwise the serial shifter takes over.
                exec_res_d      = a_q;
                exec_is_shift_d = (shamt_q != '0);
            end
            default: begin
                exec_res_d = '0;
                exec_ill_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            funct_q  <= '0;
            shamt_q  <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= src1;
                        b_q     <= src2;
                        funct_q <= funct;
                        shamt_q <= shamt;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (exec_is_shift_d) begin
                        shreg_q <= a_q;
                        cnt_q   <= shamt_q;
                        state_q <= S_SHIFT;
                    end else begin
                        result_q <= exec_res_d;
                        zero_q   <= (exec_res_d == '0);
                        ovf_q    <= exec_ovf_d;
                        ill_q    <= exec_ill_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end

                S_SHIFT: begin
                    shreg_q <= shift_next_d;
                    cnt_q   <= cnt_q - 1'b1;
                    // Last shift: the post-shift value is the result, so it
                    // is taken from the combinational next value, not shreg_q.
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q <= shift_next_d;
                        zero_q   <= (shift_next_d == '0);
                        ovf_q    <= 1'b0;
                        ill_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end

                S_DONE: begin
                    // start is deliberately ignored here.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32, SHAMT_W=5).
// Expected values come from a behavioural model using signed 64-bit
// arithmetic and native shifts; latency is derived from the operation rules.
// ----------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_seq #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct    (funct),
        .src1     (src1),
        .src2     (src2),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] F_ADD = 6'b001001;
    localparam logic [5:0] F_SUB = 6'b001010;
    localparam logic [5:0] F_OR  = 6'b010010;
    localparam logic [5:0] F_SRL = 6'b100010;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: result, flags and done latency (in edges).
    function automatic void model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] r, output bit ov,
                                  output bit il, output int lat);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        ov  = 0;
        il  = 0;
        lat = 2;
        case (f)
            F_ADD: begin
                s  = sa + sb;
                r  = a + b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            F_SUB: begin
                s  = sa - sb;
                r  = a - b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            F_OR:  r = a | b;
            F_SRL: begin
                r   = a >> sh;
                lat = (sh == 0) ? 2 : int'(sh) + 2;
            end
            default: begin
                r  = 32'd0;
                il = 1;
            end
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    // hold=1 keeps start high with scrambled inputs the whole time.
    task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit hold);
        logic [31:0] er;
        bit eov, eil;
        int elat;
        int edges;
        int busy_bad;
        bit got_done;
        logic [31:0] held;
        model(f, a, b, sh, er, eov, eil, elat);
        start = 1'b1; funct = f; src1 = a; src2 = b; shamt = sh;
        @(posedge clk);
        edges = 1; busy_bad = 0; got_done = 0;
        while (edges < 64) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (hold) begin
                start = 1'b1;
                funct = 6'($urandom);
                src1  = $urandom;
                src2  = $urandom;
                shamt = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
        end
        if (!got_done) @(negedge clk);
        chk({tag, ".done"}, {31'd0, got_done}, 32'd1);
        chk({tag, ".latency"}, edges, elat);
        chk({tag, ".busy_while_running"}, busy_bad, 0);
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ".result"}, result, er);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eov});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, eil});
        held = result;
        // In hold mode start stays high through DONE, which must ignore it.
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, ".idle_not_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".result_held"}, result, held);
    endtask

    initial begin
        bit seen;
        logic [5:0] fsel [5];
        rst = 1'b1; start = 1'b0; funct = '0; src1 = '0; src2 = '0; shamt = '0;
        fsel[0] = F_ADD; fsel[1] = F_SUB; fsel[2] = F_OR; fsel[3] = F_SRL; fsel[4] = 6'b000000;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.zero", {31'd0, zero}, 32'd1);
        chk("reset.overflow", {31'd0, overflow}, 32'd0);
        chk("reset.illegal", {31'd0, illegal}, 32'd0);

        do_op("add_ovf", F_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 0);
        do_op("sub_zero", F_SUB, 32'd5, 32'd5, 5'd0, 0);
        do_op("sub_ovf", F_SUB, 32'h80000000, 32'd1, 5'd0, 0);
        do_op("or", F_OR, 32'hF0F00000, 32'h0000F0F0, 5'd0, 0);
        do_op("srl31", F_SRL, 32'h80000000, 32'd0, 5'd31, 0);
        do_op("srl0", F_SRL, 32'hDEADBEEF, 32'd0, 5'd0, 0);
        do_op("srl1", F_SRL, 32'hFFFFFFFF, 32'd0, 5'd1, 0);
        do_op("illegal", 6'b000000, 32'h12345678, 32'h9ABCDEF0, 5'd3, 0);
        do_op("add_after_ill", F_ADD, 32'd3, 32'd4, 5'd0, 0);
        do_op("hold_add", F_ADD, 32'h00000010, 32'h00000020, 5'd0, 1);
        do_op("hold_srl", F_SRL, 32'hA5A5A5A5, 32'd0, 5'd7, 1);
        do_op("hold_sub", F_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 1);

        // Reset in the middle of a 20-position shift.
        start = 1'b1; funct = F_SRL; src1 = 32'hFFFF0000; src2 = '0; shamt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk("midrst.result", result, 32'd0);
        chk("midrst.zero", {31'd0, zero}, 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("midrst.no_done_after", {31'd0, seen}, 32'd0);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            logic [5:0] f;
            logic [4:0] sh;
            f  = fsel[$urandom_range(0, 4)];
            if (f == 6'b000000) f = 6'($urandom);
            sh = (i % 3 == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
            do_op($sformatf("rnd%0d", i), f, $urandom, $urandom, sh, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
